// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes (also used by the ALU control decoder),
// default widths and the execute-stage FSM encoding.
package alu_pkg;

   localparam int DATA_W_DEF  = 32;
   localparam int SHAMT_W_DEF = 5;

   localparam logic [3:0] ALU_AND = 4'd0;
   localparam logic [3:0] ALU_OR  = 4'd1;
   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_SLL = 4'd3;
   localparam logic [3:0] ALU_SRL = 4'd4;
   localparam logic [3:0] ALU_SUB = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd7;
   localparam logic [3:0] ALU_MUL = 4'd8;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } alu_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_W cycles
// per product. done/product are combinational in the final iteration cycle.
module seq_multiplier #(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = 5
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              load,
   input  logic              kill,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              done,
   output logic [DATA_W-1:0] product
);

   localparam logic [SHAMT_W-1:0] LAST_ITER = SHAMT_W'(DATA_W - 1);

   logic [DATA_W-1:0]  multiplicand;
   logic [DATA_W-1:0]  multiplier;
   logic [DATA_W-1:0]  accumulator;
   logic [SHAMT_W-1:0] counter;
   logic               active;
   logic [DATA_W-1:0]  partial;

   // The final add is folded into product so the result is ready the cycle done is high.
   always_comb begin
      partial = multiplier[0] ? multiplicand : '0;
      product = accumulator + partial;
      done    = active && (counter == LAST_ITER);
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         multiplicand <= '0;
         multiplier   <= '0;
         accumulator  <= '0;
         counter      <= '0;
         active       <= 1'b0;
      end else if (load) begin
         multiplicand <= a;
         multiplier   <= b;
         accumulator  <= '0;
         counter      <= '0;
         active       <= 1'b1;
      end else if (kill) begin
         active <= 1'b0;
      end else if (active) begin
         accumulator  <= product;
         multiplicand <= multiplicand << 1;
         multiplier   <= multiplier >> 1;
         counter      <= counter + 1'b1;
         if (done) begin
            active <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle ops return a registered result one cycle after
// start; MUL runs on the iterative multiplier and holds busy until it completes.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int SHAMT_W = SHAMT_W_DEF
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              start,
   input  logic              kill,
   input  logic [3:0]        alu_control,
   input  logic [DATA_W-1:0] operand_a,
   input  logic [DATA_W-1:0] operand_b,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              result_valid,
   output logic              busy
);

   alu_state_t        state;
   alu_state_t        next_state;
   logic              mul_load;
   logic              single_fire;
   logic              mul_fire;
   logic              mul_done;
   logic [DATA_W-1:0] mul_product;
   logic [DATA_W-1:0] alu_result;
   logic [DATA_W-1:0] final_result;
   logic              slt_bit;

   seq_multiplier #(
      .DATA_W (DATA_W),
      .SHAMT_W(SHAMT_W)
   ) u_mult (
      .clk    (clk),
      .arst_n (arst_n),
      .load   (mul_load),
      .kill   (kill),
      .a      (operand_a),
      .b      (operand_b),
      .done   (mul_done),
      .product(mul_product)
   );

   always_comb begin
      slt_bit    = $signed(operand_a) < $signed(operand_b);
      alu_result = '0;
      case (alu_control)
         ALU_AND: alu_result = operand_a & operand_b;
         ALU_OR:  alu_result = operand_a | operand_b;
         ALU_ADD: alu_result = operand_a + operand_b;
         ALU_SLL: alu_result = operand_a << operand_b[SHAMT_W-1:0];
         ALU_SRL: alu_result = operand_a >> operand_b[SHAMT_W-1:0];
         ALU_SUB: alu_result = operand_a - operand_b;
         ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, slt_bit};
         default: alu_result = '0;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // kill beats both a new start and a multiply that is about to finish.
   always_comb begin
      next_state  = state;
      mul_load    = 1'b0;
      single_fire = 1'b0;
      mul_fire    = 1'b0;
      case (state)
         IDLE: begin
            if (start && !kill) begin
               if (alu_control == ALU_MUL) begin
                  mul_load   = 1'b1;
                  next_state = MUL;
               end else begin
                  single_fire = 1'b1;
               end
            end
         end
         MUL: begin
            if (kill) begin
               next_state = IDLE;
            end else if (mul_done) begin
               mul_fire   = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   assign final_result = mul_fire ? mul_product : alu_result;
   assign busy         = (state == MUL);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         result       <= '0;
         zero         <= 1'b1;
         result_valid <= 1'b0;
      end else begin
         result_valid <= single_fire | mul_fire;
         if (single_fire || mul_fire) begin
            result <= final_result;
            zero   <= (final_result == '0);
         end
      end
   end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Execute-stage ALU that consumes the 4-bit `alu_control` code produced by the ALU control decoder and performs the operation on two operands. Single-cycle operations return a registered result one cycle after `start`. `MUL` runs on an iterative shift-add multiplier and asserts `busy` so the pipeline can stall. It sits between the ID/EX pipeline register and the EX/MEM register.

## Interface
Parameters:
- `DATA_W`, default 32: operand and result width; a power of 2, at least 8.
- `SHAMT_W`, default 5: shift-amount width, equal to log2(`DATA_W`).

Ports:
- Clock and reset: one clock, `clk`; reset is asynchronous and active-low, `arst_n`.
- `clk`  in  1  clock.
- `arst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request; sampled only in `IDLE`.
- `kill`  in  1  synchronous abort (pipeline flush).
- `alu_control`  in  4  operation code.
- `operand_a`  in  `DATA_W`  first operand.
- `operand_b`  in  `DATA_W`  second operand / shift amount.
- `result`  out  `DATA_W`  registered result; holds until the next completion.
- `zero`  out  1  registered `result == 0`; updates with `result`.
- `result_valid`  out  1  one-cycle pulse per completed operation.
- `busy`  out  1  high while a multiply is in progress.

## Operation
- Operation codes:
  - `AND`=0: a&b
  - `OR`=1: a|b
  - `ADD`=2: a+b, mod 2^DATA_W
  - `SLL`=3: a << b[SHAMT_W-1:0]
  - `SRL`=4: logical a >> b[SHAMT_W-1:0]
  - `SUB`=6: a-b, mod 2^DATA_W
  - `SLT`=7: signed a<b ? 1 : 0
  - `MUL`=8: low `DATA_W` bits of a*b
  - Any other code: result 0; it still completes in one cycle with `result_valid`.
- FSM states: `IDLE`, `MUL`.
  - `IDLE` with `start` and a non-`MUL` code: compute, load `result`/`zero`, pulse `result_valid` next cycle; stay in `IDLE`.
  - `IDLE` with `start` and `MUL`: capture a into the multiplicand register and b into the multiplier register, clear the accumulator and counter; go to `MUL`.
  - `MUL`, each cycle:
    - if multiplier[0], accumulator += multiplicand;
    - multiplicand <<= 1; multiplier >>= 1; counter++.
    - After `DATA_W` iterations, load `result` = accumulator (including the final add) and `zero`, pulse `result_valid`, return to `IDLE`.
- `start` while in `MUL` is ignored; upstream must hold the instruction while `busy` is high.
- `kill`:
  - in `MUL`: return to `IDLE`, no `result_valid`, `result`/`zero` unchanged;
  - in `IDLE` with `start`: the request is dropped (`kill` wins);
  - with no operation pending: no effect.
- Reset values, also applied on reset mid-multiply: state `IDLE`, `result`=0, `zero`=1, `result_valid`=0, `busy`=0, counter and internal registers 0.

## Timing
- Cycle 0 means `start` is sampled high in `IDLE`.
- Single-cycle ops:
  - `result_valid`=1 and `result` valid in cycle 1.
  - Back-to-back `start` every cycle is allowed, giving one result per cycle.
- `MUL`:
  - `busy`=1 in cycles 1..`DATA_W` (`busy` is decoded from state only).
  - `result_valid`=1 in cycle `DATA_W`+1, with `busy`=0 in the same cycle.
  - A new `start` is accepted in cycle `DATA_W`+1.
- Upstream stall equation: `busy | (start & alu_control==MUL)`. This equation belongs to the hazard unit, not this block.
- `result_valid` is never high for two consecutive cycles from one request.
- `result_valid` is never asserted in a cycle where `busy`=1.

## Structure
- Shared package `alu_pkg`:
  - the eight operation-code constants, also used by the ALU control decoder;
  - `DATA_W`/`SHAMT_W` defaults;
  - the FSM state encoding.
- One sub-module, `seq_multiplier`:
  - owns the multiplicand, multiplier, accumulator and counter;
  - ports: `clk`, `arst_n`, `load`, `kill`, `a`, `b`, `done`, `product`.
- The top level holds the FSM, the combinational single-cycle datapath and the output registers.

## Test plan
- Reset, then `ADD` a=7, b=5 -> cycle 1: `result`=12, `zero`=0, `result_valid`=1; cycle 2: `result_valid`=0, `result` holds 12.
- Back-to-back operations:
  - `SUB` 3-3 -> `result`=0, `zero`=1.
  - `SLT` a=0xFFFFFFFF, b=1 -> 1.
  - `SRL` a=0x80000000, b=0x21 (shift 1) -> 0x40000000.
  - Code 5 -> 0.
  - Expect four consecutive `result_valid` pulses.
- `MUL` a=0x12345678, b=0x10 -> `busy` high for cycles 1..32; cycle 33: `result`=0x23456780, `result_valid`=1. A `start` with `ADD` during `busy` is ignored.
- `MUL` a=0xFFFFFFFF, b=0xFFFFFFFF -> `result`=1. An immediately following `MUL` started in cycle 33 completes in cycle 66.
- Disruptions:
  - `kill` in cycle 10 of a `MUL` -> `busy`=0 in cycle 11, no `result_valid`, `result` unchanged.
  - `start`+`kill` together -> nothing.
  - `arst_n` low in cycle 15 of a `MUL` -> all outputs at reset values immediately; the FSM is idle on release.
